sha256_msg_padder: RTL and testbench

Upstream stage of the SHA-256 core. Accepts a message as a byte stream with a valid/ready handshake, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and emits 512-bit blocks as sixteen big-endian 32-bit words per block. The words feed the compression core's message loader over a second valid/ready handshake. Messages are accepted back to back.

---
 rtl/sha256_msg_padder.sv | 222 ++++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Byte-stream front end for the SHA-256 core. It applies the standard
//   message padding (0x80 marker, zero fill, 64-bit big-endian bit length)
//   and emits each 512-bit block as sixteen big-endian 32-bit words.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   in_valid/in_ready         byte handshake; in_data = byte,
//   in_keep, in_last          in_last ends the message, in_keep=0 on the
//                             last beat means the beat carries no byte
//   w_valid/w_ready           word handshake to the message loader
//   w_data                    word; first byte of the word in [31:24]
//   w_idx                     word index within the block (0..15)
//   w_eom                     word 15 of the message's final block
//   busy                      padding in progress or message partly taken
//
// One byte slot exists per cycle whenever the output register is free or
// draining (slot_en). Every source of bytes (message, marker, zero fill,
// length) competes for the same slot, so throughput is one byte per cycle.

// Staging byte for one lane of the output word. Lane 3 never needs a
// register: its byte goes straight into w_data together with lanes 0..2.
module sha256_pad_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [1:0] lane,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  dout <= '0;
    else if (wr_en && lane == LANE) dout <= din;
  end

endmodule

module sha256_msg_padder #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_keep,
  input  logic        in_last,
  output logic        in_ready,
  output logic        w_valid,
  output logic [31:0] w_data,
  input  logic        w_ready,
  output logic [3:0]  w_idx,
  output logic        w_eom,
  output logic        busy
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    MSG  = 2'd0,
    PAD  = 2'd1,
    ZERO = 2'd2,
    LEN  = 2'd3
  } state_t;

  state_t                          state, nxt_state;
  logic [CNT_W-1:0]                cnt;
  logic [5:0]                      pos;      // byte position inside the block
  logic [5:0]                      pos_inc;
  logic [1:0]                      lane;
  logic [63:0]                     len_q;    // shifts left, MSB byte goes out
  logic [2:0]                      len_cnt;
  logic                            got_byte; // current message has a byte in
  logic [NUM_LANES-2:0][7:0]       stage;

  logic       slot_en;
  logic       wr_en;
  logic [7:0] wr_byte;
  logic       cnt_inc;
  logic       len_load;
  logic       len_shift;
  logic       last_len;
  logic       emit;
  logic       w_take;

  // Lane is the low bits of the block position: every write advances both.
  assign lane    = pos[1:0];
  assign pos_inc = pos + 6'd1;
  assign slot_en = !w_valid || w_ready;
  assign w_take  = w_valid && w_ready;
  assign emit    = wr_en && (lane == 2'd3);
  assign busy    = (state != MSG) || got_byte;

  // Staging lanes 0..2
  for (genvar g = 0; g < NUM_LANES - 1; g++) begin : g_lane
    sha256_pad_lane #(
      .LANE (2'(g))
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .lane    (lane),
      .din     (wr_byte),
      .dout    (stage[g])
    );
  end

  // Next state / slot source selection
  always_comb begin
    nxt_state = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_byte   = 8'h00;
    cnt_inc   = 1'b0;
    len_load  = 1'b0;
    len_shift = 1'b0;
    last_len  = 1'b0;
    case (state)
      MSG: begin
        in_ready = slot_en;
        if (in_valid && slot_en) begin
          // in_keep only matters on the terminating beat
          if (!in_last || in_keep) begin
            wr_en   = 1'b1;
            wr_byte = in_data;
            cnt_inc = 1'b1;
          end
          if (in_last) nxt_state = PAD;
        end
      end
      PAD: begin
        if (slot_en) begin
          wr_en   = 1'b1;
          wr_byte = 8'h80;
          if (pos_inc == 6'd56) begin
            nxt_state = LEN;
            len_load  = 1'b1;
          end else begin
            nxt_state = ZERO;
          end
        end
      end
      ZERO: begin
        // Entered only with pos != 56, so the fill always writes at least
        // one zero; if the marker landed at 56..63 this wraps into a new block.
        if (slot_en) begin
          wr_en   = 1'b1;
          wr_byte = 8'h00;
          if (pos_inc == 6'd56) begin
            nxt_state = LEN;
            len_load  = 1'b1;
          end
        end
      end
      LEN: begin
        if (slot_en) begin
          wr_en     = 1'b1;
          wr_byte   = len_q[63:56];
          len_shift = 1'b1;
          if (len_cnt == 3'd7) begin
            nxt_state = MSG;
            last_len  = 1'b1;
          end
        end
      end
      default: nxt_state = MSG;
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= MSG;
      cnt      <= '0;
      pos      <= '0;
      len_q    <= '0;
      len_cnt  <= '0;
      got_byte <= 1'b0;
    end else begin
      state <= nxt_state;
      if (last_len)     pos <= '0;
      else if (wr_en)   pos <= pos_inc;
      if (last_len)     cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (last_len)     got_byte <= 1'b0;
      else if (cnt_inc) got_byte <= 1'b1;
      // cnt is final once PAD is reached, so latching on LEN entry is safe
      if (len_load) begin
        len_q   <= 64'({cnt, 3'b000});
        len_cnt <= '0;
      end else if (len_shift) begin
        len_q   <= {len_q[55:0], 8'h00};
        len_cnt <= len_cnt + 3'd1;
      end
    end
  end

  // Output word register. A new word can only be emitted in a slot, and a
  // slot requires the previous word to be gone or leaving this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_valid <= 1'b0;
      w_data  <= '0;
      w_idx   <= '0;
      w_eom   <= 1'b0;
    end else begin
      if (emit) begin
        w_valid <= 1'b1;
        w_data  <= {stage[0], stage[1], stage[2], wr_byte};
        w_eom   <= last_len;
      end else if (w_take) begin
        w_valid <= 1'b0;
        w_eom   <= 1'b0;
      end
      // Index advances on handoff, so it already names the next word
      if (w_take) w_idx <= w_idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid, in_keep, in_last, in_ready;
  logic [7:0]  in_data;
  logic        w_valid, w_ready, w_eom, busy;
  logic [31:0] w_data;
  logic [3:0]  w_idx;

  always #5 clk = ~clk;

  sha256_msg_padder #(.CNT_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_keep  (in_keep),
    .in_last  (in_last),
    .in_ready (in_ready),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .w_idx    (w_idx),
    .w_eom    (w_eom),
    .busy     (busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  idx;
    logic        eom;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] got[$];
  logic [7:0]  m[$];
  logic [7:0]  e[$];
  int          tests = 0;
  int          fails = 0;
  bit          rand_rdy = 0;
  logic        rdy_s, vld_s;
  logic [31:0] dat_s;
  logic [3:0]  idx_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gw(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length
  function automatic void expect_msg(input logic [7:0] msg[$]);
    logic [7:0]  b[$];
    logic [63:0] bits;
    exp_t        x;
    int          nw;
    b = msg;
    bits = 64'(msg.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(bits[i*8 +: 8]);
    nw = b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      x.d   = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      x.idx = 4'(w % 16);
      x.eom = (w == nw - 1);
      sb.push_back(x);
    end
  endfunction

  // Only the complete words of an unterminated message
  function automatic void expect_partial(input logic [7:0] msg[$]);
    exp_t x;
    for (int w = 0; w < msg.size() / 4; w++) begin
      x.d   = {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
      x.idx = 4'(w % 16);
      x.eom = 1'b0;
      sb.push_back(x);
    end
  endfunction

  // One clock: sample at negedge, score any handoff, drive after posedge
  task automatic cyc();
    exp_t x;
    @(negedge clk);
    rdy_s = in_ready;
    vld_s = w_valid;
    dat_s = w_data;
    idx_s = w_idx;
    if (reset_n && w_valid && w_ready) begin
      got.push_back(w_data);
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL extra_word: observed %h idx %0d, scoreboard empty", w_data, w_idx);
      end
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("w_data", 64'(w_data), 64'(x.d));
        chk("w_idx", 64'(w_idx), 64'(x.idx));
        chk("w_eom", 64'(w_eom), 64'(x.eom));
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) w_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] msg[$], input bit term);
    int n, beats, t;
    n = msg.size();
    beats = (n == 0) ? 1 : n;
    for (int i = 0; i < beats; i++) begin
      in_valid = 1'b1;
      in_data  = (n == 0) ? 8'h00 : msg[i];
      in_keep  = (n != 0);
      in_last  = term && (i == beats - 1);
      t = 0;
      do begin
        cyc();
        t++;
      end while (!rdy_s && t < 500);
      if (!rdy_s) chk("accept_timeout", 64'(rdy_s), 64'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      cyc();
      t++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (6) cyc();
  endtask

  initial begin
    in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0;
    w_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_w_data", 64'(w_data), 64'd0);
    chk("rst_w_idx", 64'(w_idx), 64'd0);
    chk("rst_w_eom", 64'(w_eom), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // "abc"
    got.delete();
    m = '{8'h61, 8'h62, 8'h63};
    expect_msg(m);
    send(m, 1);
    drain();
    chk("abc_words", 64'(got.size()), 64'd16);
    chk("abc_w0", 64'(gw(0)), 64'h61626380);
    chk("abc_w15", 64'(gw(15)), 64'h18);

    // empty message
    got.delete();
    e.delete();
    expect_msg(e);
    send(e, 1);
    drain();
    chk("empty_w0", 64'(gw(0)), 64'h80000000);
    chk("empty_w15", 64'(gw(15)), 64'h0);

    // 55 bytes: single block
    got.delete();
    m.delete();
    repeat (55) m.push_back(8'h00);
    expect_msg(m);
    send(m, 1);
    drain();
    chk("b55_words", 64'(got.size()), 64'd16);
    chk("b55_w13", 64'(gw(13)), 64'h80);
    chk("b55_w15", 64'(gw(15)), 64'h1B8);

    // 56 bytes: length spills into a second block
    got.delete();
    m.push_back(8'h00);
    expect_msg(m);
    send(m, 1);
    drain();
    chk("b56_words", 64'(got.size()), 64'd32);
    chk("b56_w14", 64'(gw(14)), 64'h80000000);
    chk("b56_w31", 64'(gw(31)), 64'h1C0);

    // backpressure on word 0
    got.delete();
    w_ready = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    expect_msg(m);
    send(m, 1);
    for (int t = 0; t < 50 && !vld_s; t++) cyc();
    repeat (10) begin
      cyc();
      chk("bp_valid", 64'(vld_s), 64'd1);
      chk("bp_data", 64'(dat_s), 64'h61626380);
      chk("bp_idx", 64'(idx_s), 64'd0);
      chk("bp_in_ready", 64'(rdy_s), 64'd0);
    end
    w_ready = 1'b1;
    drain();
    chk("bp_words", 64'(got.size()), 64'd16);

    // 100 random bytes under random w_ready
    m.delete();
    for (int i = 0; i < 100; i++) m.push_back(8'($urandom_range(0, 255)));
    expect_msg(m);
    rand_rdy = 1;
    send(m, 1);
    drain();
    rand_rdy = 0;
    w_ready = 1'b1;

    // reset in the middle of a message
    m.delete();
    for (int i = 0; i < 37; i++) m.push_back(8'(i + 1));
    expect_partial(m);
    send(m, 0);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_sb", 64'(sb.size()), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(w_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_idx", 64'(w_idx), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) begin
      cyc();
      chk("post_rst_idle", 64'(vld_s), 64'd0);
    end
    got.delete();
    m = '{8'h61, 8'h62, 8'h63};
    expect_msg(m);
    send(m, 1);
    drain();
    chk("post_rst_words", 64'(got.size()), 64'd16);
    chk("post_rst_w0", 64'(gw(0)), 64'h61626380);
    chk("post_rst_w15", 64'(gw(15)), 64'h18);

    // back to back: "abc" then ""
    got.delete();
    e.delete();
    expect_msg(m);
    expect_msg(e);
    send(m, 1);
    send(e, 1);
    drain();
    chk("b2b_words", 64'(got.size()), 64'd32);
    chk("b2b_w16", 64'(gw(16)), 64'h80000000);
    chk("b2b_w31", 64'(gw(31)), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
